// File: rtl/branch_predictor.sv
// Bimodal 2-bit-counter branch direction predictor, 1-cycle query latency, trained at commit.
// Define BP_GSHARE_EN to XOR a committed global history register into the table index.
module branch_predictor #(
  parameter int         XLEN            = 32,
  parameter int         BHT_INDEX_WIDTH = 8,
  parameter logic [1:0] CNT_INIT        = 2'b01,
  parameter int         GHR_WIDTH       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            if_query_valid,
  input  logic [XLEN-1:0] if_query_addr,
  input  logic            rob_bp_enable,
  input  logic [XLEN-1:0] rob_bp_inst_addr,
  input  logic            rob_bp_jump,
  input  logic            rob_bp_correct,
  output logic            bp_pred_valid,
  output logic            bp_pred_jump,
  output logic [31:0]     bp_branch_cnt,
  output logic [31:0]     bp_miss_cnt
);

  localparam int ENTRIES = 1 << BHT_INDEX_WIDTH;

  logic [1:0]                 cnt [ENTRIES];
  logic [BHT_INDEX_WIDTH-1:0] hist;
  logic [BHT_INDEX_WIDTH-1:0] query_idx;
  logic [BHT_INDEX_WIDTH-1:0] upd_idx;
  logic [1:0]                 upd_old;
  logic [1:0]                 upd_new;
  logic [1:0]                 query_cnt;
  logic                       unused_addr_bits;

`ifdef BP_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr;

  assign hist = BHT_INDEX_WIDTH'(ghr);

  // History is shifted only by committed branches, so flush never needs to repair it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (rob_bp_enable) begin
      ghr <= {ghr[GHR_WIDTH-2:0], rob_bp_jump};
    end
  end
`else
  assign hist = '0;
`endif

  assign query_idx = if_query_addr[BHT_INDEX_WIDTH:1] ^ hist;
  assign upd_idx   = rob_bp_inst_addr[BHT_INDEX_WIDTH:1] ^ hist;

  assign unused_addr_bits = ^{if_query_addr[XLEN-1:BHT_INDEX_WIDTH+1], if_query_addr[0],
                              rob_bp_inst_addr[XLEN-1:BHT_INDEX_WIDTH+1], rob_bp_inst_addr[0]};

  always_comb begin
    upd_old = cnt[upd_idx];
    upd_new = upd_old;
    if (rob_bp_jump) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
    end
  end

  // A same-cycle update to the queried entry is forwarded so the guess sees the trained value.
  always_comb begin
    query_cnt = cnt[query_idx];
    if (rob_bp_enable && (upd_idx == query_idx)) query_cnt = upd_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_INIT;
    end else if (rob_bp_enable) begin
      cnt[upd_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_pred_valid <= 1'b0;
      bp_pred_jump  <= 1'b0;
    end else if (flush) begin
      bp_pred_valid <= 1'b0;
      bp_pred_jump  <= 1'b0;
    end else if (!stall) begin
      bp_pred_valid <= if_query_valid;
      bp_pred_jump  <= if_query_valid & query_cnt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_branch_cnt <= '0;
      bp_miss_cnt   <= '0;
    end else if (rob_bp_enable) begin
      bp_branch_cnt <= bp_branch_cnt + 32'd1;
      bp_miss_cnt   <= bp_miss_cnt + {31'd0, ~rob_bp_correct};
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table of per-cycle stimulus/expectations plus an
// asynchronous-reset sequence (and a history-indexing check when BP_GSHARE_EN is defined).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall;
  logic        if_query_valid;
  logic [31:0] if_query_addr;
  logic        rob_bp_enable;
  logic [31:0] rob_bp_inst_addr;
  logic        rob_bp_jump;
  logic        rob_bp_correct;
  logic        bp_pred_valid;
  logic        bp_pred_jump;
  logic [31:0] bp_branch_cnt;
  logic [31:0] bp_miss_cnt;

  int errors = 0;
  int checks = 0;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .stall            (stall),
    .if_query_valid   (if_query_valid),
    .if_query_addr    (if_query_addr),
    .rob_bp_enable    (rob_bp_enable),
    .rob_bp_inst_addr (rob_bp_inst_addr),
    .rob_bp_jump      (rob_bp_jump),
    .rob_bp_correct   (rob_bp_correct),
    .bp_pred_valid    (bp_pred_valid),
    .bp_pred_jump     (bp_pred_jump),
    .bp_branch_cnt    (bp_branch_cnt),
    .bp_miss_cnt      (bp_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        qv;
    logic [31:0] qa;
    logic        ue;
    logic [31:0] ua;
    logic        uj;
    logic        uc;
    logic        st;
    logic        fl;
    logic        ev;
    logic        ej;
    logic [31:0] ebr;
    logic [31:0] emiss;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic qv, input logic [31:0] qa, input logic ue,
                              input logic [31:0] ua, input logic uj, input logic uc,
                              input logic st, input logic fl, input logic ev, input logic ej,
                              input logic [31:0] ebr, input logic [31:0] emiss);
    vec_t v;
    v.qv = qv; v.qa = qa; v.ue = ue; v.ua = ua; v.uj = uj; v.uc = uc;
    v.st = st; v.fl = fl; v.ev = ev; v.ej = ej; v.ebr = ebr; v.emiss = emiss;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic ej,
                           input logic [31:0] ebr, input logic [31:0] emiss);
    check({tag, " pred_valid"}, {31'd0, bp_pred_valid}, {31'd0, ev});
    check({tag, " pred_jump"}, {31'd0, bp_pred_jump}, {31'd0, ej});
    check({tag, " branch_cnt"}, bp_branch_cnt, ebr);
    check({tag, " miss_cnt"}, bp_miss_cnt, emiss);
  endtask

  task automatic idle();
    flush = 0; stall = 0; if_query_valid = 0; if_query_addr = '0;
    rob_bp_enable = 0; rob_bp_inst_addr = '0; rob_bp_jump = 0; rob_bp_correct = 1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    idle();
    apply_reset();
    check_all("reset", 1'b0, 1'b0, 32'd0, 32'd0);

`ifdef BP_GSHARE_EN
    // Taken update at 0x000 trains entry 0 (ghr=0); the next query of 0x000 goes to entry 1.
    rob_bp_enable = 1; rob_bp_inst_addr = 32'h0; rob_bp_jump = 1; rob_bp_correct = 1;
    @(posedge clk); #1 idle();
    if_query_valid = 1; if_query_addr = 32'h0;
    @(posedge clk); #1 idle();
    check_all("gshare q0", 1'b1, 1'b0, 32'd1, 32'd0);
`else
    //  qv  qa            ue  ua            uj  uc  st  fl  ev  ej  br  miss
    add(1, 32'h100,       0, 32'h0,         0,  1,  0,  0,  1,  0,  0,  0);
    add(0, 32'h0,         1, 32'h100,       1,  0,  0,  0,  0,  0,  1,  1);
    add(0, 32'h0,         1, 32'h100,       1,  0,  0,  0,  0,  0,  2,  2);
    add(1, 32'h100,       0, 32'h0,         0,  1,  0,  0,  1,  1,  2,  2);
    for (int k = 0; k < 5; k++)
      add(0, 32'h0,       1, 32'h104,       1,  1,  0,  0,  0,  0,  3 + k, 2);
    add(0, 32'h0,         1, 32'h104,       0,  0,  0,  0,  0,  0,  8,  3);
    add(1, 32'h104,       0, 32'h0,         0,  1,  0,  0,  1,  1,  8,  3);
    add(0, 32'h0,         1, 32'h104,       0,  1,  0,  0,  0,  0,  9,  3);
    add(0, 32'h0,         1, 32'h104,       0,  1,  0,  0,  0,  0, 10,  3);
    for (int k = 0; k < 4; k++)
      add(1, 32'h104,     1, 32'h104,       0,  1,  0,  0,  1,  0, 11 + k, 3);
    add(1, 32'h104,       0, 32'h0,         0,  1,  0,  0,  1,  0, 14,  3);
    add(1, 32'h108,       1, 32'h108,       1,  1,  0,  0,  1,  1, 15,  3);
    add(1, 32'h10A,       0, 32'h0,         0,  1,  0,  0,  1,  0, 15,  3);
    add(1, 32'h109,       0, 32'h0,         0,  1,  0,  0,  1,  1, 15,  3);
    add(1, 32'h108,       0, 32'h0,         0,  1,  0,  0,  1,  1, 15,  3);
    add(1, 32'h10A,       0, 32'h0,         0,  1,  1,  0,  1,  1, 15,  3);
    add(0, 32'h0,         0, 32'h0,         0,  1,  1,  0,  1,  1, 15,  3);
    add(1, 32'h10A,       1, 32'h10A,       1,  0,  1,  1,  0,  0, 16,  4);
    add(1, 32'h10A,       0, 32'h0,         0,  1,  0,  0,  1,  1, 16,  4);
    add(1, 32'h100,       0, 32'h0,         0,  1,  0,  0,  1,  1, 16,  4);

    for (int i = 0; i < vecs.size(); i++) begin
      if_query_valid = vecs[i].qv; if_query_addr = vecs[i].qa;
      rob_bp_enable = vecs[i].ue; rob_bp_inst_addr = vecs[i].ua;
      rob_bp_jump = vecs[i].uj; rob_bp_correct = vecs[i].uc;
      stall = vecs[i].st; flush = vecs[i].fl;
      @(posedge clk);
      #1;
      $display("vec %0d: qv=%0b qa=0x%0h ue=%0b ua=0x%0h uj=%0b st=%0b fl=%0b -> valid=%0b jump=%0b br=%0d miss=%0d",
               i, vecs[i].qv, vecs[i].qa, vecs[i].ue, vecs[i].ua, vecs[i].uj, vecs[i].st,
               vecs[i].fl, bp_pred_valid, bp_pred_jump, bp_branch_cnt, bp_miss_cnt);
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ej, vecs[i].ebr, vecs[i].emiss);
    end
    idle();

    // Reset asserted mid-cycle clears outputs at once, with no clock edge.
    if_query_valid = 1; if_query_addr = 32'h100;
    @(posedge clk); #1;
    check_all("pre-rst", 1'b1, 1'b1, 32'd16, 32'd4);
    #2 rst = 1'b1;
    #1;
    $display("async rst: valid=%0b jump=%0b br=%0d miss=%0d", bp_pred_valid, bp_pred_jump,
             bp_branch_cnt, bp_miss_cnt);
    check_all("async-rst", 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_all("post-rst q100", 1'b1, 1'b0, 32'd0, 32'd0);
    idle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
